// File: rtl/game_level_timer_if.sv
// rtl/game_level_timer_if.sv - menu-side / level-timer signal bundle; LT_PAUSE_EN adds pausa
interface game_level_timer_if #(
    parameter int TIME_WIDTH = 7
);
    logic [2:0]            estado;
    logic [1:0]            nvl;
    logic                  cn;
    logic                  meta;
    logic                  choque;
`ifdef LT_PAUSE_EN
    logic                  pausa;
`endif
    logic                  mov_tick;
    logic [TIME_WIDTH-1:0] tiempo;
    logic [1:0]            nvl_latched;
    logic                  activo;
    logic                  gano;
    logic                  perdio;

    modport master (
`ifdef LT_PAUSE_EN
        output pausa,
`endif
        output estado, nvl, cn, meta, choque,
        input  mov_tick, tiempo, nvl_latched, activo, gano, perdio
    );

    modport slave (
`ifdef LT_PAUSE_EN
        input  pausa,
`endif
        input  estado, nvl, cn, meta, choque,
        output mov_tick, tiempo, nvl_latched, activo, gano, perdio
    );
endinterface

// File: rtl/game_level_timer.sv
// rtl/game_level_timer.sv - level latch, vehicle move tick, seconds countdown, win/lose FSM; LT_PAUSE_EN adds pause gating
module game_level_timer #(
    parameter int SEC_DIV    = 50000000,
    parameter int MOV_DIV_L0 = 5000000,
    parameter int MOV_DIV_L1 = 3750000,
    parameter int MOV_DIV_L2 = 2500000,
    parameter int MOV_DIV_L3 = 1250000,
    parameter int TIME_WIDTH = 7,
    parameter int TIME_START = 60
) (
    input logic               clk,
    input logic               rst,
    game_level_timer_if.slave lt
);
    localparam int MOV_MAX01 = (MOV_DIV_L0 > MOV_DIV_L1) ? MOV_DIV_L0 : MOV_DIV_L1;
    localparam int MOV_MAX23 = (MOV_DIV_L2 > MOV_DIV_L3) ? MOV_DIV_L2 : MOV_DIV_L3;
    localparam int MOV_MAX   = (MOV_MAX01 > MOV_MAX23) ? MOV_MAX01 : MOV_MAX23;
    localparam int MOV_W     = (MOV_MAX > 1) ? $clog2(MOV_MAX) : 1;
    localparam int SEC_W     = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;
    localparam logic [SEC_W-1:0]      SEC_LAST = SEC_W'(SEC_DIV - 1);
    localparam logic [TIME_WIDTH-1:0] T_START  = TIME_WIDTH'(TIME_START);
    localparam logic [TIME_WIDTH-1:0] T_ONE    = TIME_WIDTH'(1);
    localparam logic [2:0] ESTADO_GAME = 3'b111;
    localparam logic [2:0] ESTADO_MENU = 3'b000;

    typedef enum logic [1:0] {IDLE, RUN, WIN, LOSE} state_t;

    state_t                state, state_nx;
    logic [MOV_W-1:0]      mov_cnt, mov_cnt_nx, mov_last;
    logic [SEC_W-1:0]      sec_cnt, sec_cnt_nx;
    logic [TIME_WIDTH-1:0] tiempo_nx;
    logic [1:0]            nvl_nx;
    logic                  tick_nx;
    logic                  count_en, clear_ev, load_ev;

    assign clear_ev = lt.cn && (lt.estado == ESTADO_MENU);
    assign load_ev  = lt.cn && (lt.estado != ESTADO_MENU);
`ifdef LT_PAUSE_EN
    assign count_en = (lt.estado == ESTADO_GAME) && !lt.pausa;
`else
    assign count_en = (lt.estado == ESTADO_GAME);
`endif

    always_comb begin
        mov_last = MOV_W'(MOV_DIV_L0 - 1);
        case (lt.nvl_latched)
            2'd1:    mov_last = MOV_W'(MOV_DIV_L1 - 1);
            2'd2:    mov_last = MOV_W'(MOV_DIV_L2 - 1);
            2'd3:    mov_last = MOV_W'(MOV_DIV_L3 - 1);
            default: mov_last = MOV_W'(MOV_DIV_L0 - 1);
        endcase
    end

    always_comb begin
        state_nx   = state;
        mov_cnt_nx = mov_cnt;
        sec_cnt_nx = sec_cnt;
        tiempo_nx  = lt.tiempo;
        nvl_nx     = lt.nvl_latched;
        tick_nx    = 1'b0;
        if (clear_ev) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: if (load_ev) begin
                    state_nx   = RUN;
                    nvl_nx     = lt.nvl;
                    tiempo_nx  = T_START;
                    mov_cnt_nx = '0;
                    sec_cnt_nx = '0;
                end
                RUN: begin
                    // Frog events win over any counting in the same cycle
                    if (lt.meta) begin
                        state_nx = WIN;
                    end else if (lt.choque) begin
                        state_nx = LOSE;
                    end else if (count_en) begin
                        if (mov_cnt == mov_last) begin
                            mov_cnt_nx = '0;
                            tick_nx    = 1'b1;
                        end else begin
                            mov_cnt_nx = mov_cnt + MOV_W'(1);
                        end
                        if (sec_cnt == SEC_LAST) begin
                            sec_cnt_nx = '0;
                            if (lt.tiempo <= T_ONE) begin
                                tiempo_nx = '0;
                                state_nx  = LOSE;
                                tick_nx   = 1'b0;
                            end else begin
                                tiempo_nx = lt.tiempo - T_ONE;
                            end
                        end else begin
                            sec_cnt_nx = sec_cnt + SEC_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            mov_cnt        <= '0;
            sec_cnt        <= '0;
            lt.mov_tick    <= 1'b0;
            lt.tiempo      <= '0;
            lt.nvl_latched <= 2'd0;
            lt.activo      <= 1'b0;
            lt.gano        <= 1'b0;
            lt.perdio      <= 1'b0;
        end else begin
            state          <= state_nx;
            mov_cnt        <= mov_cnt_nx;
            sec_cnt        <= sec_cnt_nx;
            lt.mov_tick    <= tick_nx;
            lt.tiempo      <= tiempo_nx;
            lt.nvl_latched <= nvl_nx;
            lt.activo      <= (state_nx == RUN);
            lt.gano        <= (state_nx == WIN);
            lt.perdio      <= (state_nx == LOSE);
        end
    end
endmodule

// File: tb/tb_game_level_timer.sv
// tb/tb_game_level_timer.sv - randomized and directed bench against an elapsed-time reference model
module tb_game_level_timer;
    localparam int SEC_DIV    = 10;
    localparam int TIME_WIDTH = 7;
    localparam int TIME_START = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    game_level_timer_if #(.TIME_WIDTH(TIME_WIDTH)) lt_bus ();

    game_level_timer #(
        .SEC_DIV(SEC_DIV), .MOV_DIV_L0(8), .MOV_DIV_L1(6), .MOV_DIV_L2(4), .MOV_DIV_L3(2),
        .TIME_WIDTH(TIME_WIDTH), .TIME_START(TIME_START)
    ) dut (
        .clk(clk),
        .rst(rst),
        .lt (lt_bus.slave)
    );

    always #5 clk = ~clk;

    // Reference: game states and time elapsed (in counted cycles) since load
    localparam int M_IDLE = 0, M_RUN = 1, M_WIN = 2, M_LOSE = 3;
    int m_state, m_elapsed, m_level, m_tiempo, m_tick;

    function automatic int div_of(input int lvl);
        case (lvl)
            0: return 8;
            1: return 6;
            2: return 4;
            default: return 2;
        endcase
    endfunction

    task automatic check_eq(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".tick"},   int'(lt_bus.mov_tick),    m_tick);
        check_eq({tag, ".tiempo"}, int'(lt_bus.tiempo),      m_tiempo);
        check_eq({tag, ".nvl"},    int'(lt_bus.nvl_latched), m_level);
        check_eq({tag, ".activo"}, int'(lt_bus.activo),      int'(m_state == M_RUN));
        check_eq({tag, ".gano"},   int'(lt_bus.gano),        int'(m_state == M_WIN));
        check_eq({tag, ".perdio"}, int'(lt_bus.perdio),      int'(m_state == M_LOSE));
    endtask

    task automatic model_reset();
        m_state = M_IDLE; m_elapsed = 0; m_level = 0; m_tiempo = 0; m_tick = 0;
    endtask

    task automatic model_step(input int e, input int n, input int c, input int mt, input int ch, input int pa);
        int rem;
        m_tick = 0;
        if (c != 0 && e == 0) begin
            m_state = M_IDLE;
        end else if (m_state == M_IDLE) begin
            if (c != 0) begin
                m_state = M_RUN; m_level = n; m_elapsed = 0; m_tiempo = TIME_START;
            end
        end else if (m_state == M_RUN) begin
            if (mt != 0) m_state = M_WIN;
            else if (ch != 0) m_state = M_LOSE;
            else if (e == 7 && pa == 0) begin
                m_elapsed++;
                rem = TIME_START - m_elapsed / SEC_DIV;
                if (rem <= 0) begin
                    m_tiempo = 0;
                    m_state  = M_LOSE;
                end else begin
                    m_tiempo = rem;
                    m_tick   = int'((m_elapsed % div_of(m_level)) == 0);
                end
            end
        end
    endtask

    task automatic step(input string tag, input int e, input int n, input int c,
                        input int mt, input int ch, input int pa);
        lt_bus.estado = 3'(e);
        lt_bus.nvl    = 2'(n);
        lt_bus.cn     = c[0];
        lt_bus.meta   = mt[0];
        lt_bus.choque = ch[0];
`ifdef LT_PAUSE_EN
        lt_bus.pausa  = pa[0];
`endif
        @(posedge clk);
        model_step(e, n, c, mt, ch, pa);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #2;
        check_eq({tag, ".async_activo"}, int'(lt_bus.activo), 0);
        check_eq({tag, ".async_tiempo"}, int'(lt_bus.tiempo), 0);
        @(posedge clk);
        model_reset();
        #1;
        check_all(tag);
        rst = 1'b0;
    endtask

    initial begin
        int e, c, mt, ch, pa, r;
        lt_bus.estado = 3'b000; lt_bus.nvl = 2'd0; lt_bus.cn = 1'b0;
        lt_bus.meta = 1'b0; lt_bus.choque = 1'b0;
`ifdef LT_PAUSE_EN
        lt_bus.pausa = 1'b0;
`endif
        model_reset();
        @(posedge clk);
        #1;
        do_reset("reset");

        // Level 2 game run to timeout
        step("load2", 7, 2, 1, 0, 0, 0);
        for (int i = 0; i < 36; i++) step("run2", 7, 0, 0, 0, 0, 0);
        step("lose_load_ignored", 7, 1, 1, 0, 0, 0);
        step("clear1", 0, 0, 1, 0, 0, 0);

        // META and CHOQUE together resolve as a win
        step("load1", 7, 1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step("run1", 7, 0, 0, 0, 0, 0);
        step("both_events", 7, 0, 0, 1, 1, 0);
        step("win_hold", 7, 0, 0, 0, 0, 0);
        step("clear_win", 0, 0, 1, 0, 0, 0);

        // Level 3 with a freeze window in the middle
        step("load3", 7, 3, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) step("run3", 7, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step("freeze", 3, 0, 0, 0, 0, 0);
`ifdef LT_PAUSE_EN
        for (int i = 0; i < 5; i++) step("pause", 7, 0, 0, 0, 0, 1);
`endif
        for (int i = 0; i < 15; i++) step("resume", 7, 0, 0, 0, 0, 0);

        // Reset in the middle of RUN, then a normal reload
        do_reset("mid_reset");
        step("reload0", 5, 0, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) step("run0", 7, 0, 0, 0, 0, 0);
        step("choque", 7, 0, 0, 0, 1, 0);
        step("clear2", 0, 0, 1, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 699) == 0) begin
                do_reset("rand_reset");
            end else begin
                r = int'($urandom_range(0, 99));
                if (r < 80) e = 7;
                else if (r < 92) e = int'($urandom_range(1, 6));
                else e = 0;
                c  = int'($urandom_range(0, 14) == 0);
                mt = int'($urandom_range(0, 59) == 0);
                ch = int'($urandom_range(0, 59) == 0);
`ifdef LT_PAUSE_EN
                pa = int'($urandom_range(0, 4) == 0);
`else
                pa = 0;
`endif
                step("rand", e, int'($urandom_range(0, 3)), c, mt, ch, pa);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
